// File: rtl/signed_restoring_divider.sv
// Sequential signed divider: restoring division on operand magnitudes, one quotient
// bit per clock, then a sign fix-up. Shares the multiplier's start/done handshake.
`timescale 1ns/1ps
module signed_restoring_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPUTE = 2'd1;
  localparam logic [1:0] S_FIXUP   = 2'd2;

  logic [1:0]       state;
  logic [WIDTH:0]   a;
  logic [WIDTH-1:0] q, m;
  logic [CW-1:0]    count;
  logic             sign_q, sign_r;

  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH+1:0] a_sh, diff;
  logic             ge;

  // Magnitudes come straight from the ports so the start edge sees fresh operands.
  always_comb begin
    dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
    dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
    a_sh    = {a, q[WIDTH-1]};
    diff    = a_sh - {2'b00, m};
    ge      = ~diff[WIDTH+1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      a           <= '0;
      q           <= '0;
      m           <= '0;
      count       <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sign_r <= dividend[WIDTH-1];
            q      <= dvd_mag;
            m      <= dvs_mag;
            a      <= '0;
            count  <= '0;
            busy   <= 1'b1;
            state  <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          // a_sh never carries into its top bit, so diff's MSB is a true borrow.
          a     <= ge ? diff[WIDTH:0] : a_sh[WIDTH:0];
          q     <= {q[WIDTH-2:0], ge};
          count <= count + 1'b1;
          if (count == CW'(WIDTH-1)) state <= S_FIXUP;
        end
        S_FIXUP: begin
          quotient    <= sign_q ? -q : q;
          remainder   <= sign_r ? -a[WIDTH-1:0] : a[WIDTH-1:0];
          div_by_zero <= (m == '0);
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_signed_restoring_divider.sv
// Self-checking bench for signed_restoring_divider: directed corner cases plus
// randomized operands against a plain-arithmetic C-semantics reference.
`timescale 1ns/1ps
module tb_signed_restoring_divider;
  localparam int W = 32;
  localparam logic [W-1:0] MIN = 32'h8000_0000;

  logic         clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic [W-1:0] quotient, remainder;
  logic         done, busy, div_by_zero;

  int n_cmp = 0, n_fail = 0;

  signed_restoring_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .done(done), .busy(busy),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // C semantics on 64-bit signed values; truncation to W wraps MIN/-1 naturally.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] rq, output logic [W-1:0] rr,
                                  output logic rz);
    longint sa, sb, lq, lr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      rq = a[W-1] ? 32'd1 : 32'hFFFF_FFFF;
      rr = a;
      rz = 1'b1;
    end else begin
      lq = sa / sb;
      lr = sa % sb;
      rq = lq[W-1:0];
      rr = lr[W-1:0];
      rz = 1'b0;
    end
  endfunction

  // Called #1 after a rising edge with the DUT idle (or in its done cycle).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] oq, output logic [W-1:0] orr,
                        output logic oz, output int lat, output int bcnt);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; bcnt = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bcnt++;
    end
    oq = quotient; orr = remainder; oz = div_by_zero;
  endtask

  task automatic test_reset;
    n_cmp++;
    if ({quotient, remainder, done, busy, div_by_zero} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got q=%h r=%h d=%b b=%b z=%b, want all 0",
               quotient, remainder, done, busy, div_by_zero);
    end
  endtask

  task automatic test_basic;
    logic [W-1:0] q, r; logic z; int lat, bc;
    run_op(32'd100, 32'd7, q, r, z, lat, bc);
    n_cmp++; if (q !== 32'd14) begin n_fail++; $display("FAIL basic_q: got %0d want 14", q); end
    n_cmp++; if (r !== 32'd2) begin n_fail++; $display("FAIL basic_r: got %0d want 2", r); end
    n_cmp++; if (z !== 1'b0) begin n_fail++; $display("FAIL basic_dz: got %b want 0", z); end
    n_cmp++; if (lat != 33) begin n_fail++; $display("FAIL basic_latency: got %0d want 33", lat); end
    n_cmp++; if (bc != 33) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 33", bc); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width: got %b want 0", done); end
    n_cmp++; if (q !== quotient) begin n_fail++; $display("FAIL result_hold: got %h want %h", quotient, q); end
  endtask

  task automatic test_directed;
    logic [W-1:0] ta[10] = '{-32'sd100, 32'd100, -32'sd100, 32'd7, 32'd5, -32'sd5,
                             MIN, MIN, 32'd0, 32'h7FFF_FFFF};
    logic [W-1:0] tb[10] = '{32'd7, -32'sd7, -32'sd7, 32'd100, 32'd0, 32'd0,
                             32'hFFFF_FFFF, 32'd2, 32'd9, MIN};
    logic [W-1:0] eq[10] = '{32'hFFFF_FFF2, -32'sd14, 32'd14, 32'd0, 32'hFFFF_FFFF, 32'd1,
                             MIN, 32'hC000_0000, 32'd0, 32'd0};
    logic [W-1:0] er[10] = '{32'hFFFF_FFFE, 32'd2, -32'sd2, 32'd7, 32'd5, -32'sd5,
                             32'd0, 32'd0, 32'd0, 32'h7FFF_FFFF};
    logic [9:0]   ez = 10'b0000_110000;
    logic [W-1:0] q, r; logic z; int lat, bc;
    for (int i = 0; i < 10; i++) begin
      run_op(ta[i], tb[i], q, r, z, lat, bc);
      n_cmp++;
      if (q !== eq[i] || r !== er[i] || z !== ez[9-i] || lat != 33) begin
        n_fail++;
        $display("FAIL directed_%0d %h/%h: got q=%h r=%h z=%b lat=%0d want q=%h r=%h z=%b lat=33",
                 i, ta[i], tb[i], q, r, z, lat, eq[i], er[i], ez[9-i]);
      end
    end
  endtask

  task automatic test_start_while_busy;
    int lat;
    start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1; start = 1'b1; dividend = 32'd7; divisor = 32'd7;
    @(posedge clk); #1; start = 1'b0; dividend = 32'd0; divisor = 32'd0;
    lat = 5;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    n_cmp++;
    if (quotient !== 32'd333 || remainder !== 32'd1 || lat != 33) begin
      n_fail++;
      $display("FAIL ignore_start: got q=%0d r=%0d lat=%0d want q=333 r=1 lat=33", quotient, remainder, lat);
    end
  endtask

  task automatic test_reset_abort;
    logic [W-1:0] q, r; logic z; int lat, bc; bit seen;
    start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    #1; rst = 1'b1; #1;
    n_cmp++;
    if ({quotient, remainder, done, busy, div_by_zero} !== '0) begin
      n_fail++;
      $display("FAIL reset_abort_outputs: got q=%h r=%h d=%b b=%b z=%b, want all 0",
               quotient, remainder, done, busy, div_by_zero);
    end
    @(posedge clk); @(posedge clk); #1; rst = 1'b0;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done || busy) seen = 1; end
    n_cmp++; if (seen) begin n_fail++; $display("FAIL reset_abort_no_done: got activity=1 want 0"); end
    run_op(32'd9, 32'd3, q, r, z, lat, bc);
    n_cmp++;
    if (q !== 32'd3 || r !== 32'd0) begin
      n_fail++; $display("FAIL after_reset_op: got q=%0d r=%0d want q=3 r=0", q, r);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] q, r; logic z; int lat, bc;
    run_op(32'd100, 32'd7, q, r, z, lat, bc);
    n_cmp++;
    if (q !== 32'd14 || r !== 32'd2 || lat != 33) begin
      n_fail++; $display("FAIL b2b_first: got q=%0d r=%0d lat=%0d want 14 2 33", q, r, lat);
    end
    run_op(32'd50, 32'd5, q, r, z, lat, bc);
    n_cmp++;
    if (q !== 32'd10 || r !== 32'd0 || lat != 33) begin
      n_fail++; $display("FAIL b2b_second: got q=%0d r=%0d lat=%0d want 10 0 33", q, r, lat);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b, q, r, eq, er; logic z, ez; int lat, bc;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom();
      b = $urandom();
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = W'($urandom_range(1, 15));
        2: b = -W'($urandom_range(1, 15));
        3: b = MIN;
        4: a = MIN;
        5: a = W'($urandom_range(0, 200));
        default: ;
      endcase
      ref_div(a, b, eq, er, ez);
      run_op(a, b, q, r, z, lat, bc);
      n_cmp++;
      if (q !== eq || r !== er || z !== ez || lat != 33) begin
        n_fail++;
        $display("FAIL random_%0d %h/%h: got q=%h r=%h z=%b lat=%0d want q=%h r=%h z=%b lat=33",
                 i, a, b, q, r, z, lat, eq, er, ez);
      end
    end
  endtask

  initial begin
    #2;
    test_reset;
    @(posedge clk); @(posedge clk); #1; rst = 1'b0;
    test_basic;
    test_directed;
    test_start_while_busy;
    test_reset_abort;
    test_back_to_back;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
